// File: rtl/eth_proto_tx_arb.sv
// Frame-atomic round-robin arbiter merging N_CH protocol byte streams onto one MAC TX port.
// Adds a programmable inter-frame gap and aborts a frame whose granted sender underruns.
module eth_proto_tx_arb #(
    parameter int N_CH        = 4,
    parameter int DATA_W      = 8,
    parameter int IFG_CYCLES  = 12,
    parameter int UNDERRUN_TO = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ch_valid_i,
    input  logic [N_CH*DATA_W-1:0]  ch_data_i,
    input  logic [N_CH-1:0]         ch_last_i,
    output logic [N_CH-1:0]         ch_ack_o,
    output logic                    mac_tx_valid_o,
    output logic [DATA_W-1:0]       mac_tx_data_o,
    output logic                    mac_tx_last_o,
    input  logic                    mac_tx_ack_i,
    output logic                    mac_tx_abort_o,
    output logic [$clog2(N_CH)-1:0] grant_o,
    output logic                    busy_o
);
    localparam int GNT_W  = $clog2(N_CH);
    localparam int GAP_W  = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
    localparam int URUN_W = $clog2(UNDERRUN_TO + 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;
    localparam logic [URUN_W-1:0] URUN_MAX = URUN_W'(UNDERRUN_TO);
    localparam logic [GNT_W-1:0]  LAST_CH  = GNT_W'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state, w_state_next;
    logic [GNT_W-1:0]    r_grant, w_grant_next;
    logic [GNT_W-1:0]    r_rr_ptr, w_rr_ptr_next;
    logic [GAP_W-1:0]    r_gap_cnt, w_gap_cnt_next;
    logic [URUN_W-1:0]   r_urun_cnt, w_urun_cnt_next;

    logic [DATA_W-1:0]   w_ch_data [N_CH];
    logic                w_arb_hit;
    logic [GNT_W-1:0]    w_arb_idx;
    logic [GNT_W:0]      w_arb_sum;
    logic                w_in_xfer;
    logic                w_g_valid;
    logic                w_g_last;
    logic [URUN_W-1:0]   w_urun_inc;
    logic                w_urun_hit;
    logic                w_frame_end;
    logic [GNT_W-1:0]    w_rr_adv;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
        assign w_ch_data[gi] = ch_data_i[gi*DATA_W +: DATA_W];
        assign ch_ack_o[gi]  = w_in_xfer & mac_tx_ack_i & (r_grant == GNT_W'(gi));
    end

    // First requester at or above rr_ptr, wrapping; the offset walk handles non-power-of-2 N_CH.
    always_comb begin
        w_arb_hit = 1'b0;
        w_arb_idx = r_rr_ptr;
        w_arb_sum = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_arb_sum = {1'b0, r_rr_ptr} + (GNT_W+1)'(i);
            if (w_arb_sum >= (GNT_W+1)'(N_CH)) begin
                w_arb_sum = w_arb_sum - (GNT_W+1)'(N_CH);
            end
            if (!w_arb_hit && ch_valid_i[w_arb_sum[GNT_W-1:0]]) begin
                w_arb_hit = 1'b1;
                w_arb_idx = w_arb_sum[GNT_W-1:0];
            end
        end
    end

    assign w_in_xfer  = (r_state == S_XFER);
    assign w_g_valid  = ch_valid_i[r_grant];
    assign w_g_last   = ch_last_i[r_grant];
    assign w_urun_inc = (r_urun_cnt == URUN_MAX) ? r_urun_cnt : r_urun_cnt + 1'b1;
    assign w_urun_hit = w_in_xfer & ~w_g_valid & (w_urun_inc == URUN_MAX);
    assign w_rr_adv   = (r_grant == LAST_CH) ? '0 : r_grant + 1'b1;

    always_comb begin
        w_state_next    = r_state;
        w_grant_next    = r_grant;
        w_rr_ptr_next   = r_rr_ptr;
        w_gap_cnt_next  = r_gap_cnt;
        w_urun_cnt_next = r_urun_cnt;
        w_frame_end     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb_hit) begin
                    w_state_next    = S_XFER;
                    w_grant_next    = w_arb_idx;
                    w_urun_cnt_next = '0;
                end
            end
            S_XFER: begin
                if (w_g_valid) begin
                    w_urun_cnt_next = '0;
                    w_frame_end     = mac_tx_ack_i & w_g_last;
                end else begin
                    w_urun_cnt_next = w_urun_inc;
                    w_frame_end     = w_urun_hit;
                end
                if (w_frame_end) begin
                    w_rr_ptr_next   = w_rr_adv;
                    w_urun_cnt_next = '0;
                    w_gap_cnt_next  = '0;
                    w_state_next    = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (r_gap_cnt >= GAP_LAST) begin
                    w_state_next   = S_IDLE;
                    w_gap_cnt_next = '0;
                end else begin
                    w_gap_cnt_next = r_gap_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_gap_cnt  <= '0;
            r_urun_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_rr_ptr   <= w_rr_ptr_next;
            r_gap_cnt  <= w_gap_cnt_next;
            r_urun_cnt <= w_urun_cnt_next;
        end
    end

    // Data is forced to zero outside XFER so the MAC never sees stale channel bytes.
    assign mac_tx_valid_o = w_in_xfer & w_g_valid;
    assign mac_tx_data_o  = w_in_xfer ? w_ch_data[r_grant] : '0;
    assign mac_tx_last_o  = w_in_xfer & w_g_last;
    assign mac_tx_abort_o = w_urun_hit;
    assign grant_o        = r_grant;
    assign busy_o         = (r_state != S_IDLE);

endmodule
